// File: rtl/cpu_defs.sv
// cpu_defs: shared constants and F/D register layout for the P7 MIPS pipeline.
package cpu_defs;
    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam int          IM_WORDS   = 4096;
    localparam logic [31:0] IM_END     = IM_BASE + 32'(4 * IM_WORDS);
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [31:0] NOP        = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        bd;
        logic [4:0]  exc;
    } fd_t;
endpackage

// File: rtl/fetch_stage_npc_sel.sv
// npc_sel: next-PC priority mux and fetch-address fault detector.
module npc_sel
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic        irq,
    input  logic        stall,
    input  logic        eret,
    input  logic        redirect,
    input  logic [31:0] epc,
    input  logic [31:0] target,
    output logic [31:0] npc,
    output logic        fault
);
    always_comb begin
        npc = irq      ? EXC_VECTOR :
              stall    ? pc         :
              eret     ? epc        :
              redirect ? target     :
                         pc + 32'd4;
        fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc >= IM_END);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and F/D pipeline register of the P7 MIPS fetch stage.
module fetch_stage
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        IRQ,
    input  logic        Eret_D,
    input  logic [31:0] EPC,
    input  logic        Redirect_D,
    input  logic [31:0] NPC_D,
    input  logic        IsBJ_D,
    input  logic [31:0] Instr_IM,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        BD_D,
    output logic [4:0]  ExcCode_D
);
    logic [31:0] npc;
    logic        fault;
    fd_t         fd, fd_cap;

    npc_sel u_npc_sel (
        .pc(PC_F),
        .irq(IRQ),
        .stall(StallF),
        .eret(Eret_D),
        .redirect(Redirect_D),
        .epc(EPC),
        .target(NPC_D),
        .npc(npc),
        .fault(fault)
    );

    // A faulting fetch still advances; the fault travels down as ExcCode with a nop.
    always_comb begin
        fd_cap.instr = fault ? NOP : Instr_IM;
        fd_cap.pc    = PC_F;
        fd_cap.pc4   = PC_F + 32'd4;
        fd_cap.bd    = IsBJ_D;
        fd_cap.exc   = fault ? EXC_ADEL : EXC_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_F <= PC_RESET;
            fd   <= '0;
        end else if (IRQ) begin
            PC_F <= npc;
            fd   <= '0;
        end else if (!StallF) begin
            PC_F <= npc;
            fd   <= Eret_D ? fd_t'('0) : fd_cap;
        end
    end

    assign Instr_D   = fd.instr;
    assign PC_D      = fd.pc;
    assign PC4_D     = fd.pc4;
    assign BD_D      = fd.bd;
    assign ExcCode_D = fd.exc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; IM returns ~address so every fetch is distinguishable.
module tb_fetch_stage;
    typedef struct packed {
        logic [31:0] pc_f;
        logic [31:0] instr;
        logic [31:0] pc_d;
        logic [31:0] pc4;
        logic        bd;
        logic [4:0]  exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, IRQ = 1'b0, Eret_D = 1'b0, Redirect_D = 1'b0, IsBJ_D = 1'b0;
    logic [31:0] EPC = '0, NPC_D = '0;
    logic [31:0] Instr_IM, PC_F, Instr_D, PC_D, PC4_D;
    logic        BD_D;
    logic [4:0]  ExcCode_D;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .IRQ(IRQ), .Eret_D(Eret_D),
        .EPC(EPC), .Redirect_D(Redirect_D), .NPC_D(NPC_D), .IsBJ_D(IsBJ_D),
        .Instr_IM(Instr_IM), .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D),
        .PC4_D(PC4_D), .BD_D(BD_D), .ExcCode_D(ExcCode_D)
    );

    assign Instr_IM = ~PC_F;
    always #5 clk = ~clk;

    function automatic exp_t observed();
        return '{PC_F, Instr_D, PC_D, PC4_D, BD_D, ExcCode_D};
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a = observed();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got pc_f=%h instr=%h pc_d=%h pc4=%h bd=%b exc=%0d expected pc_f=%h instr=%h pc_d=%h pc4=%h bd=%b exc=%0d",
                     name, a.pc_f, a.instr, a.pc_d, a.pc4, a.bd, a.exc,
                     e.pc_f, e.instr, e.pc_d, e.pc4, e.bd, e.exc);
        end
    endtask

    // Monitor: after each rising edge, pop the expectation for that edge.
    int edge_no = 0;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            edge_no++;
            compare($sformatf("edge%0d", edge_no), q.pop_front());
        end
    end

    task automatic step(input logic st, irq, er, rd, bj, input logic [31:0] npc, epc,
                        input logic [31:0] e_pcf, e_ins, e_pcd, e_pc4,
                        input logic e_bd, input logic [4:0] e_exc);
        StallF = st; IRQ = irq; Eret_D = er; Redirect_D = rd; IsBJ_D = bj;
        NPC_D = npc; EPC = epc;
        q.push_back('{e_pcf, e_ins, e_pcd, e_pc4, e_bd, e_exc});
        @(negedge clk);
    endtask

    initial begin
        #12;
        compare("reset", '{32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0});
        @(negedge clk);
        reset = 1'b0;
        //   st irq er rd bj  npc           epc           pc_f          instr         pc_d          pc4         bd exc
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h3004,     ~32'h3000,    32'h3000,     32'h3004,     0, 0);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h3008,     ~32'h3004,    32'h3004,     32'h3008,     0, 0);
        step(0, 0, 0, 1, 1, 32'h3100,     32'h0,    32'h3100,     ~32'h3008,    32'h3008,     32'h300C,     1, 0);
        step(1, 0, 0, 1, 1, 32'h3200,     32'h0,    32'h3100,     ~32'h3008,    32'h3008,     32'h300C,     1, 0);
        step(1, 0, 1, 1, 1, 32'h3200,     32'h5000, 32'h3100,     ~32'h3008,    32'h3008,     32'h300C,     1, 0);
        step(0, 0, 0, 1, 1, 32'h3200,     32'h0,    32'h3200,     ~32'h3100,    32'h3100,     32'h3104,     1, 0);
        step(1, 1, 1, 1, 1, 32'h3300,     32'h3400, 32'h4180,     32'h0,        32'h0,        32'h0,        0, 0);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h4184,     ~32'h4180,    32'h4180,     32'h4184,     0, 0);
        step(0, 0, 1, 0, 1, 32'h0,        32'h3204, 32'h3204,     32'h0,        32'h0,        32'h0,        0, 0);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h3208,     ~32'h3204,    32'h3204,     32'h3208,     0, 0);
        step(0, 0, 0, 1, 0, 32'h3102,     32'h0,    32'h3102,     ~32'h3208,    32'h3208,     32'h320C,     0, 0);
        step(0, 0, 0, 1, 0, 32'h2FFC,     32'h0,    32'h2FFC,     32'h0,        32'h3102,     32'h3106,     0, 4);
        step(0, 0, 0, 1, 0, 32'h7000,     32'h0,    32'h7000,     32'h0,        32'h2FFC,     32'h3000,     0, 4);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h7004,     32'h0,        32'h7000,     32'h7004,     0, 4);
        step(0, 1, 0, 0, 0, 32'h0,        32'h0,    32'h4180,     32'h0,        32'h0,        32'h0,        0, 0);
        step(0, 0, 0, 1, 0, 32'h6FFC,     32'h0,    32'h6FFC,     ~32'h4180,    32'h4180,     32'h4184,     0, 0);
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0,   32'hFFFF_FFFC, ~32'h6FFC,   32'h6FFC,     32'h7000,     0, 0);
        step(0, 0, 0, 0, 0, 32'h0,        32'h0,    32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       0, 4);
        step(0, 0, 0, 0, 1, 32'h0,        32'h0,    32'h4,        32'h0,        32'h0,        32'h4,        1, 4);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        StallF = 1'b1;
        IRQ = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1 compare("async_reset", '{32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
